// File: rtl/s_axi4l_reg_bank_if.sv
// Register-access strobes between the AXI4-Lite channel stages and the register bank.
// Signal names follow the bank's point of view.
interface s_axi4l_reg_bank_if #(
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 4,
   parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
);
   logic [AXI_ADDR_WIDTH-1:0] i_raddr;
   logic                      i_raddr_valid;
   logic [AXI_DATA_WIDTH-1:0] o_rdata;
   logic [AXI_ADDR_WIDTH-1:0] i_waddr;
   logic [AXI_DATA_WIDTH-1:0] i_wdata;
   logic [AXI_STRB_WIDTH-1:0] i_wstrb;
   logic                      i_wvalid;

   modport master (
      output i_raddr, i_raddr_valid, i_waddr, i_wdata, i_wstrb, i_wvalid,
      input  o_rdata
   );

   modport slave (
      input  i_raddr, i_raddr_valid, i_waddr, i_wdata, i_wstrb, i_wvalid,
      output o_rdata
   );
endinterface

// File: rtl/s_axi4l_reg_bank.sv
// Four-register bank (CTRL, SCRATCH, STATUS W1C, COUNTER) behind the AXI4-Lite channel stages.
// Reads are combinational from the read address; writes land on the strobed edge.
module s_axi4l_reg_bank #(
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 4,
   parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
   parameter int NUM_EVENTS     = 8
) (
   input  logic                      i_axi_clock,
   input  logic                      i_axi_aresetn,
   s_axi4l_reg_bank_if.slave         bus,
   input  logic [NUM_EVENTS-1:0]     i_event,
   output logic                      o_enable,
   output logic [7:0]                o_irq_mask,
   output logic                      o_irq,
   output logic [AXI_DATA_WIDTH-1:0] o_count
);
   localparam logic [1:0] REG_CTRL    = 2'd0;
   localparam logic [1:0] REG_SCRATCH = 2'd1;
   localparam logic [1:0] REG_STATUS  = 2'd2;
   localparam logic [1:0] REG_COUNTER = 2'd3;
   localparam logic [AXI_DATA_WIDTH-1:0] CNT_ONE = {{(AXI_DATA_WIDTH-1){1'b0}}, 1'b1};

   logic                      r_enable;
   logic [7:0]                r_irq_mask;
   logic [AXI_DATA_WIDTH-1:0] r_scratch;
   logic [NUM_EVENTS-1:0]     r_status;
   logic [AXI_DATA_WIDTH-1:0] r_count;
   logic                      r_irq;

   logic                      w_wr_ctrl;
   logic                      w_wr_scratch;
   logic                      w_wr_status;
   logic                      w_cnt_clear;
   logic [NUM_EVENTS-1:0]     w_status_clr;

   assign w_wr_ctrl    = bus.i_wvalid && (bus.i_waddr[3:2] == REG_CTRL);
   assign w_wr_scratch = bus.i_wvalid && (bus.i_waddr[3:2] == REG_SCRATCH);
   assign w_wr_status  = bus.i_wvalid && (bus.i_waddr[3:2] == REG_STATUS);
   assign w_cnt_clear  = w_wr_ctrl && bus.i_wstrb[0] && bus.i_wdata[1];
   // All event flags live in byte lane 0, so only that strobe gates the clear.
   assign w_status_clr = (w_wr_status && bus.i_wstrb[0]) ? bus.i_wdata[NUM_EVENTS-1:0] : '0;

   always_ff @(posedge i_axi_clock or negedge i_axi_aresetn) begin
      if (!i_axi_aresetn) begin
         r_enable   <= 1'b0;
         r_irq_mask <= '0;
         r_status   <= '0;
         r_count    <= '0;
         r_irq      <= 1'b0;
      end else begin
         if (w_wr_ctrl && bus.i_wstrb[0]) r_enable   <= bus.i_wdata[0];
         if (w_wr_ctrl && bus.i_wstrb[1]) r_irq_mask <= bus.i_wdata[15:8];
         // Enable is the pre-edge value, so an enable written this beat counts from next cycle.
         if (w_cnt_clear)   r_count <= '0;
         else if (r_enable) r_count <= r_count + CNT_ONE;
         r_status <= (r_status & ~w_status_clr) | i_event;
         r_irq    <= |(r_status & r_irq_mask[NUM_EVENTS-1:0]);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < AXI_STRB_WIDTH; gi++) begin : g_scratch_lane
         always_ff @(posedge i_axi_clock or negedge i_axi_aresetn) begin
            if (!i_axi_aresetn)
               r_scratch[gi*8 +: 8] <= 8'h00;
            else if (w_wr_scratch && bus.i_wstrb[gi])
               r_scratch[gi*8 +: 8] <= bus.i_wdata[gi*8 +: 8];
         end
      end
   endgenerate

   always_comb begin
      bus.o_rdata = '0;
      case (bus.i_raddr[3:2])
         REG_CTRL: begin
            bus.o_rdata[0]    = r_enable;
            bus.o_rdata[15:8] = r_irq_mask;
         end
         REG_SCRATCH: bus.o_rdata = r_scratch;
         REG_STATUS:  bus.o_rdata[NUM_EVENTS-1:0] = r_status;
         REG_COUNTER: bus.o_rdata = r_count;
         default:     bus.o_rdata = '0;
      endcase
   end

   assign o_enable   = r_enable;
   assign o_irq_mask = r_irq_mask;
   assign o_irq      = r_irq;
   assign o_count    = r_count;
endmodule

// File: tb/tb_s_axi4l_reg_bank.sv
// Bench for s_axi4l_reg_bank: table of register accesses plus hand-written sequences
// for counter, STATUS/IRQ timing and reset-during-write.
module tb_s_axi4l_reg_bank;
   logic        clk;
   logic        aresetn;
   logic [7:0]  ev;
   logic        enable;
   logic [7:0]  irq_mask;
   logic        irq;
   logic [31:0] count;

   int checks = 0;
   int errors = 0;

   logic [31:0] sb_exp[$];
   string       sb_name[$];

   typedef struct {
      bit          is_wr;
      logic [3:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[13];

   s_axi4l_reg_bank_if #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(4)) bus ();

   s_axi4l_reg_bank #(
      .AXI_DATA_WIDTH(32),
      .AXI_ADDR_WIDTH(4),
      .NUM_EVENTS(8)
   ) dut (
      .i_axi_clock  (clk),
      .i_axi_aresetn(aresetn),
      .bus          (bus),
      .i_event      (ev),
      .o_enable     (enable),
      .o_irq_mask   (irq_mask),
      .o_irq        (irq),
      .o_count      (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end else begin
         $display("ok   %s value=0x%08h", name, act);
      end
   endtask

   // Read scoreboard: expectation queued at issue, compared mid-cycle while the strobe is up.
   always @(negedge clk) begin
      if (bus.i_raddr_valid === 1'b1) begin
         if (sb_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow actual=0x%08h required=<none>", bus.o_rdata);
         end else begin
            chk(sb_name.pop_front(), bus.o_rdata, sb_exp.pop_front());
         end
      end
   end

   function automatic vec_t mk(input bit w, input logic [3:0] a, input logic [31:0] d,
                               input logic [3:0] s, input logic [31:0] e, input string n);
      vec_t v;
      v.is_wr = w; v.addr = a; v.data = d; v.strb = s; v.exp = e; v.name = n;
      return v;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      bus.i_waddr  = a;
      bus.i_wdata  = d;
      bus.i_wstrb  = s;
      bus.i_wvalid = 1'b1;
      @(posedge clk);
      #1;
      bus.i_wvalid = 1'b0;
      $display("wr   addr=0x%h data=0x%08h strb=0x%h", a, d, s);
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] e, input string n);
      bus.i_raddr       = a;
      bus.i_raddr_valid = 1'b1;
      sb_exp.push_back(e);
      sb_name.push_back(n);
      @(posedge clk);
      #1;
      bus.i_raddr_valid = 1'b0;
   endtask

   initial begin
      vecs[0]  = mk(1'b0, 4'h0, 32'h0,        4'h0, 32'h0,        "rst_ctrl");
      vecs[1]  = mk(1'b0, 4'h4, 32'h0,        4'h0, 32'h0,        "rst_scratch");
      vecs[2]  = mk(1'b0, 4'h8, 32'h0,        4'h0, 32'h0,        "rst_status");
      vecs[3]  = mk(1'b0, 4'hC, 32'h0,        4'h0, 32'h0,        "rst_counter");
      vecs[4]  = mk(1'b1, 4'h4, 32'hA5A5A5A5, 4'hF, 32'h0,        "");
      vecs[5]  = mk(1'b1, 4'h4, 32'h12345678, 4'h5, 32'h0,        "");
      vecs[6]  = mk(1'b0, 4'h4, 32'h0,        4'h0, 32'hA534A578, "scratch_strb");
      vecs[7]  = mk(1'b0, 4'h6, 32'h0,        4'h0, 32'hA534A578, "scratch_lowaddr");
      vecs[8]  = mk(1'b1, 4'h0, 32'hFFFF5AFC, 4'hF, 32'h0,        "");
      vecs[9]  = mk(1'b0, 4'h0, 32'h0,        4'h0, 32'h00005A00, "ctrl_rsvd_bits");
      vecs[10] = mk(1'b1, 4'h0, 32'h00000000, 4'h1, 32'h0,        "");
      vecs[11] = mk(1'b1, 4'h4, 32'hFFFFFFFF, 4'h0, 32'h0,        "");
      vecs[12] = mk(1'b0, 4'h4, 32'h0,        4'h0, 32'hA534A578, "scratch_strb0");

      aresetn = 1'b0;
      ev = '0;
      bus.i_raddr = '0; bus.i_raddr_valid = 1'b0;
      bus.i_waddr = '0; bus.i_wdata = '0; bus.i_wstrb = '0; bus.i_wvalid = 1'b0;
      idle(3);
      chk("rst_enable", {31'b0, enable}, 32'h0);
      chk("rst_irq", {31'b0, irq}, 32'h0);
      chk("rst_count", count, 32'h0);
      aresetn = 1'b1;
      idle(1);

      for (int i = 0; i < 13; i++) begin
         if (vecs[i].is_wr) wr(vecs[i].addr, vecs[i].data, vecs[i].strb);
         else               rd(vecs[i].addr, vecs[i].exp, vecs[i].name);
      end
      chk("irq_mask_out", {24'b0, irq_mask}, 32'h5A);
      wr(4'h0, 32'h0, 4'h2);

      // Counter: enable, run, clear while counting, disable, ignored write to COUNTER.
      wr(4'h0, 32'h1, 4'h1);
      chk("cnt_start", count, 32'd0);
      idle(10);
      rd(4'hC, 32'd10, "cnt_after_10");
      wr(4'h0, 32'h3, 4'h1);
      chk("cnt_cleared", count, 32'd0);
      idle(1);
      chk("cnt_restart", count, 32'd1);
      rd(4'h0, 32'h1, "ctrl_clr_reads0");
      wr(4'h0, 32'h0, 4'h1);
      chk("cnt_stopped", count, 32'd3);
      chk("enable_off", {31'b0, enable}, 32'h0);
      wr(4'hC, 32'hFFFFFFFF, 4'hF);
      rd(4'hC, 32'd3, "cnt_ro");

      // STATUS / IRQ timing.
      wr(4'h0, 32'h00000400, 4'h2);
      ev = 8'h04;
      idle(1);
      ev = 8'h00;
      chk("irq_lat1", {31'b0, irq}, 32'h0);
      idle(1);
      chk("irq_set", {31'b0, irq}, 32'h1);
      rd(4'h8, 32'h4, "status_set");
      wr(4'h8, 32'h4, 4'h1);
      chk("irq_hold", {31'b0, irq}, 32'h1);
      idle(1);
      chk("irq_clr", {31'b0, irq}, 32'h0);
      rd(4'h8, 32'h0, "status_w1c");
      ev = 8'h04;
      wr(4'h8, 32'h4, 4'h1);
      ev = 8'h00;
      rd(4'h8, 32'h4, "status_set_wins");
      wr(4'h8, 32'h4, 4'h1);
      rd(4'h8, 32'h0, "status_clr2");
      ev = 8'h20;
      idle(1);
      ev = 8'h00;
      idle(2);
      chk("irq_masked", {31'b0, irq}, 32'h0);
      wr(4'h8, 32'hFF, 4'h2);
      rd(4'h8, 32'h20, "status_wrong_lane");
      wr(4'h8, 32'h20, 4'h1);
      rd(4'h8, 32'h0, "status_clr3");

      // Reset asserted in the middle of a write.
      wr(4'h0, 32'h00000401, 4'h3);
      idle(3);
      bus.i_raddr  = 4'h4;
      bus.i_waddr  = 4'h4;
      bus.i_wdata  = 32'hDEADBEEF;
      bus.i_wstrb  = 4'hF;
      bus.i_wvalid = 1'b1;
      #2;
      aresetn = 1'b0;
      #1;
      chk("arst_enable", {31'b0, enable}, 32'h0);
      chk("arst_mask", {24'b0, irq_mask}, 32'h0);
      chk("arst_count", count, 32'h0);
      chk("arst_rdata", bus.o_rdata, 32'h0);
      @(posedge clk);
      #1;
      bus.i_wvalid = 1'b0;
      aresetn = 1'b1;
      rd(4'h4, 32'h0, "arst_write_lost");
      rd(4'h0, 32'h0, "arst_ctrl");
      idle(2);
      chk("arst_no_count", count, 32'h0);

      idle(2);
      chk("sb_drain", sb_exp.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/s_axi4l_reg_bank.md
Name: s_axi4l_reg_bank

Overview:
Register bank that sits directly downstream of the AXI4-Lite slave read and write channel stages. It consumes the single-cycle register access strobes those stages produce: raddr/raddr_valid from the read channel and waddr/wdata/wstrb/wvalid from the write channel. It returns read data combinationally and implements four 32-bit registers: CTRL (RW), SCRATCH (RW), STATUS (sticky, W1C) and COUNTER (RO). It drives the control, interrupt and counter outputs into the user logic.

Parameters:
AXI_DATA_WIDTH, 32, data width; fixed at 32 for this register map.
AXI_ADDR_WIDTH, 4, byte address width; addr[3:2] selects the register, addr[1:0] is ignored.
AXI_STRB_WIDTH, AXI_DATA_WIDTH/8, byte-strobe width.
NUM_EVENTS, 8, number of event inputs; legal range 1..8.

Ports:
i_axi_clock  in  1  clock
i_axi_aresetn  in  1  asynchronous active-low reset
i_raddr  in  AXI_ADDR_WIDTH  read address from the read channel
i_raddr_valid  in  1  one-cycle read strobe
o_rdata  out  AXI_DATA_WIDTH  read data, combinational from i_raddr
i_waddr  in  AXI_ADDR_WIDTH  write address from the write channel
i_wdata  in  AXI_DATA_WIDTH  write data
i_wstrb  in  AXI_STRB_WIDTH  byte strobes
i_wvalid  in  1  one-cycle write strobe
i_event  in  NUM_EVENTS  level event inputs, sampled each clock
o_enable  out  1  CTRL[0]
o_irq_mask  out  8  CTRL[15:8]
o_irq  out  1  registered interrupt
o_count  out  AXI_DATA_WIDTH  COUNTER value

Behaviour:
Clock and reset: clock i_axi_clock; reset i_axi_aresetn, asynchronous, active-low.
- On reset, all registers clear to 0. o_enable=0, o_irq_mask=0, o_irq=0, o_count=0.
- o_rdata during reset reflects the zeroed registers.
- Reset asserted mid-access discards the access. No state survives reset.

Register map (byte address):
- 0x0 CTRL
  - [0] enable, RW.
  - [1] counter clear: write-1 pulse, self-clearing, always reads 0.
  - [15:8] irq mask, RW.
  - All other bits read 0 and ignore writes.
- 0x4 SCRATCH: full 32-bit RW.
- 0x8 STATUS
  - [NUM_EVENTS-1:0] sticky event flags; write 1 to clear.
  - Upper bits read 0.
- 0xC COUNTER: RO; writes are ignored.

Writes:
- Take effect on the rising edge where i_wvalid=1; new value is visible the next cycle.
- Byte lane k is written only if i_wstrb[k]=1. This applies to CTRL, SCRATCH and STATUS W1C.
- i_wstrb=0 is a no-op.
- Only i_waddr[3:2] is decoded.

Reads:
- o_rdata = register selected by i_raddr[3:2], purely combinational, independent of i_raddr_valid.
- Zero added latency, so the upstream stage can capture o_rdata in the same cycle as i_raddr_valid.
- i_raddr_valid has no side effects; reads are non-destructive. It is kept as a port for future clear-on-read registers.

STATUS:
- Each cycle, STATUS[i] <= (STATUS[i] & ~clr[i]) | i_event[i].
- clr[i] = i_wvalid & addr==0x8 & wstrb[0] & wdata[i].
- If set and clear coincide, set wins.

COUNTER:
- Increments by 1 each cycle while CTRL[0]=1. Wraps 0xFFFFFFFF -> 0.
- A CTRL write with wdata[1]=1 and wstrb[0]=1 loads 0 on that edge. Clear overrides increment.
- The enable bit written in the same beat takes effect from the next cycle.

IRQ:
- o_irq <= |(STATUS[NUM_EVENTS-1:0] & CTRL[8 +: NUM_EVENTS]), registered.
- One cycle after STATUS or mask changes.

Simultaneous read and write to the same address: o_rdata shows the pre-edge value in that cycle and the new value from the next cycle.

Test Plan:
- Reset, then read 0x0/0x4/0x8/0xC -> all return 0x00000000; o_irq=0, o_enable=0.
- Write SCRATCH 0xA5A5A5A5 strb=0xF, then 0x12345678 strb=0x5 -> read 0x4 returns 0xA534A578.
- Write CTRL 0x00000001, wait 10 cycles, read COUNTER -> value 9 or 10 per cycle alignment (bench computes exact); write CTRL 0x00000003 -> COUNTER=0 next cycle, then increments; CTRL reads 0x00000001.
- Pulse i_event[2] one cycle with mask 0x04 -> STATUS=0x4, o_irq=1 two cycles after the event. Write 0x8 data 0x4 -> STATUS=0, o_irq=0 next cycle. Hold event high during the W1C write -> STATUS stays 0x4.
- Preload COUNTER near wrap by running it (force-free) from a bench-set enable over 2^32 is impractical; instead run with AXI_DATA_WIDTH fixed and check via o_count that a CTRL clear during increment yields 0. Write to 0xC 0xFFFFFFFF -> COUNTER unchanged.
- Assert i_axi_aresetn low mid-write with i_wvalid=1 -> all registers 0 immediately, write lost after release.
